reg_access_arbiter: RTL and testbench

- Sequences and shares the single-port 8-bit control/status register file between two requesters.
  - Port A: I2C serial engine.
  - Port B: local host/sequencer.
- Owns the register-file port signals: address, write data, write enable, registered read data.
- Register-file read timing: read data is registered, valid one clock after the address is presented.
- Provides per-requester req/ack handshake, round-robin fairness, and write protection for status (read-only) addresses.

---
 rtl/reg_access_arbiter.sv | 157 +++++++++++++++
 tb/tb_reg_access_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_arbiter.sv
// Two-requester arbiter for a single-port 8-bit register file.
// Round-robin grant, write protection for status addresses, and registered read capture.
module reg_access_arbiter #(
   parameter int NUM_REGS    = 8,
   parameter int NUM_WR_REGS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   // requester A (I2C engine)
   input  logic       req_a,
   input  logic       we_a,
   input  logic [7:0] addr_a,
   input  logic [7:0] wdata_a,
   output logic       ack_a,
   output logic [7:0] rdata_a,
   output logic       err_a,
   // requester B (local host/sequencer)
   input  logic       req_b,
   input  logic       we_b,
   input  logic [7:0] addr_b,
   input  logic [7:0] wdata_b,
   output logic       ack_b,
   output logic [7:0] rdata_b,
   output logic       err_b,
   // register-file port
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   // Handshake: req is a level held until the one-cycle ack pulse; we/addr/wdata
   // are sampled only in the grant cycle, later changes on the request side are ignored.

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Bounds widened to 9 bits so NUM_REGS = 256 still compares correctly.
   localparam logic [8:0] LP_NUM_REGS    = 9'(NUM_REGS);
   localparam logic [8:0] LP_NUM_WR_REGS = 9'(NUM_WR_REGS);

   state_t     r_state;
   logic       r_gnt_b;
   logic       r_last_b;
   logic       r_we;

   logic       w_any_req;
   logic       w_pick_b;
   logic       w_sel_we;
   logic [7:0] w_sel_addr;
   logic [7:0] w_sel_wdata;
   logic       w_sel_wr_ok;
   logic       w_addr_wr_ok;
   logic       w_addr_valid;

   assign w_any_req = req_a | req_b;
   // B wins when it is alone, or when both request and A was served last.
   assign w_pick_b  = req_b & (~req_a | ~r_last_b);

   assign w_sel_we    = w_pick_b ? we_b    : we_a;
   assign w_sel_addr  = w_pick_b ? addr_b  : addr_a;
   assign w_sel_wdata = w_pick_b ? wdata_b : wdata_a;

   assign w_sel_wr_ok  = ({1'b0, w_sel_addr} < LP_NUM_WR_REGS);
   assign w_addr_wr_ok = ({1'b0, reg_addr}   < LP_NUM_WR_REGS);
   assign w_addr_valid = ({1'b0, reg_addr}   < LP_NUM_REGS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_gnt_b   <= 1'b0;
         r_last_b  <= 1'b1;
         r_we      <= 1'b0;
         reg_addr  <= 8'h00;
         reg_wdata <= 8'h00;
         reg_we    <= 1'b0;
         busy      <= 1'b0;
         ack_a     <= 1'b0;
         rdata_a   <= 8'h00;
         err_a     <= 1'b0;
         ack_b     <= 1'b0;
         rdata_b   <= 8'h00;
         err_b     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_gnt_b   <= w_pick_b;
                  r_last_b  <= w_pick_b;
                  r_we      <= w_sel_we;
                  reg_addr  <= w_sel_addr;
                  reg_wdata <= w_sel_wdata;
                  // Write enable is registered so it is high exactly during ISSUE.
                  reg_we    <= w_sel_we & w_sel_wr_ok;
                  busy      <= 1'b1;
                  r_state   <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               reg_we <= 1'b0;
               if (r_we) begin
                  if (r_gnt_b) begin
                     ack_b <= 1'b1;
                     err_b <= ~w_addr_wr_ok;
                  end else begin
                     ack_a <= 1'b1;
                     err_a <= ~w_addr_wr_ok;
                  end
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_CAPTURE;
               end
            end

            ST_CAPTURE: begin
               // reg_rdata now reflects the address presented during ISSUE.
               if (r_gnt_b) begin
                  rdata_b <= w_addr_valid ? reg_rdata : 8'h00;
                  ack_b   <= 1'b1;
                  err_b   <= ~w_addr_valid;
               end else begin
                  rdata_a <= w_addr_valid ? reg_rdata : 8'h00;
                  ack_a   <= 1'b1;
                  err_a   <= ~w_addr_valid;
               end
               r_state <= ST_DONE;
            end

            ST_DONE: begin
               if (r_gnt_b) begin
                  ack_b <= 1'b0;
                  err_b <= 1'b0;
               end else begin
                  ack_a <= 1'b0;
                  err_a <= 1'b0;
               end
               reg_we  <= 1'b0;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               reg_we  <= 1'b0;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a small registered register-file model.
module tb_reg_access_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_a, we_a, ack_a, err_a;
   logic [7:0] addr_a, wdata_a, rdata_a;
   logic       req_b, we_b, ack_b, err_b;
   logic [7:0] addr_b, wdata_b, rdata_b;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_we, busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   reg_access_arbiter #(.NUM_REGS(8), .NUM_WR_REGS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .ack_a(ack_a), .rdata_a(rdata_a), .err_a(err_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .ack_b(ack_b), .rdata_b(rdata_b), .err_b(err_b),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
      .reg_rdata(reg_rdata), .busy(busy)
   );

   // Register-file model: 8 entries, initial contents 00,11,22,33,44,C3,66,77.
   logic [7:0] mem [0:7];
   logic       mem_loaded = 1'b0;

   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 8; i++) mem[i] <= (i == 5) ? 8'hC3 : 8'(i * 17);
         mem_loaded <= 1'b1;
      end else if (reg_we && reg_addr < 8'd8) begin
         mem[reg_addr[2:0]] <= reg_wdata;
      end
      reg_rdata <= (reg_addr < 8'd8) ? mem[reg_addr[2:0]] : 8'hEE;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic run_txn(input string tag, input logic side_b, input logic we,
                          input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rdata, input logic exp_err);
      int         cyc;
      logic       got;
      int         we_cnt;
      logic [7:0] we_addr;
      logic [7:0] we_data;
      logic       other_ack;
      logic       exp_pulse;
      exp_pulse = we && (addr < 8'd4);
      cyc = 0; got = 1'b0; we_cnt = 0; other_ack = 1'b0;
      we_addr = 8'h00; we_data = 8'h00;
      @(negedge clk);
      if (side_b) begin
         req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
      end else begin
         req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
      end
      while (!got && cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (reg_we) begin
            we_cnt++; we_addr = reg_addr; we_data = reg_wdata;
         end
         if (side_b ? ack_a : ack_b) other_ack = 1'b1;
         got = side_b ? ack_b : ack_a;
      end
      chk({tag, "_ack_seen"}, 32'(got), 32'd1);
      chk({tag, "_latency"}, 32'(cyc), we ? 32'd2 : 32'd3);
      chk({tag, "_err"}, 32'(side_b ? err_b : err_a), 32'(exp_err));
      if (!we) chk({tag, "_rdata"}, 32'(side_b ? rdata_b : rdata_a), 32'(exp_rdata));
      chk({tag, "_we_pulses"}, 32'(we_cnt), 32'(exp_pulse));
      if (exp_pulse) begin
         chk({tag, "_we_addr"}, 32'(we_addr), 32'(addr));
         chk({tag, "_we_data"}, 32'(we_data), 32'(wdata));
      end
      chk({tag, "_other_ack"}, 32'(other_ack), 32'd0);
      if (side_b) req_b = 1'b0; else req_a = 1'b0;
      @(negedge clk);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_ack_after"}, 32'(side_b ? ack_b : ack_a), 32'd0);
   endtask

   initial begin
      int         cyc;
      logic       got;
      logic [7:0] exp_rb;
      rst_n = 1'b0;
      req_a = 1'b0; we_a = 1'b0; addr_a = 8'h00; wdata_a = 8'h00;
      req_b = 1'b0; we_b = 1'b0; addr_b = 8'h00; wdata_b = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ack_a", 32'(ack_a), 32'd0);
      chk("rst_ack_b", 32'(ack_b), 32'd0);
      chk("rst_reg_we", 32'(reg_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_reg_addr", 32'(reg_addr), 32'd0);
      chk("rst_rdata_a", 32'(rdata_a), 32'd0);
      rst_n = 1'b1;

      // A permitted write, then A read of a status address
      run_txn("a_wr02", 1'b0, 1'b1, 8'h02, 8'h5A, 8'h00, 1'b0);
      chk("mem2_written", 32'(mem[2]), 32'h5A);
      run_txn("a_rd05", 1'b0, 1'b0, 8'h05, 8'h00, 8'hC3, 1'b0);

      // Protected write and out-of-range read
      run_txn("a_wr06_ro", 1'b0, 1'b1, 8'h06, 8'h77, 8'h00, 1'b1);
      chk("mem6_intact", 32'(mem[6]), 32'h66);
      run_txn("b_rd09_oor", 1'b1, 1'b0, 8'h09, 8'h00, 8'h00, 1'b1);
      chk("rdata_a_kept", 32'(rdata_a), 32'hC3);

      // Continuous contention: A reads 01, B reads 03; expect A,B,A,B
      exp_rb = 8'h00;
      @(negedge clk);
      req_a = 1'b1; we_a = 1'b0; addr_a = 8'h01;
      req_b = 1'b1; we_b = 1'b0; addr_b = 8'h03;
      for (int t = 0; t < 4; t++) begin
         got = 1'b0; cyc = 0;
         while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            got = ack_a | ack_b;
         end
         chk($sformatf("rr%0d_ack_seen", t), 32'(got), 32'd1);
         chk($sformatf("rr%0d_ack_a", t), 32'(ack_a), (t % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("rr%0d_ack_b", t), 32'(ack_b), (t % 2 == 1) ? 32'd1 : 32'd0);
         if (t % 2 == 0) begin
            chk($sformatf("rr%0d_rdata_a", t), 32'(rdata_a), 32'h11);
            chk($sformatf("rr%0d_rdata_b_kept", t), 32'(rdata_b), 32'(exp_rb));
            req_a = 1'b0;
         end else begin
            exp_rb = 8'h33;
            chk($sformatf("rr%0d_rdata_b", t), 32'(rdata_b), 32'(exp_rb));
            chk($sformatf("rr%0d_rdata_a_kept", t), 32'(rdata_a), 32'h11);
            req_b = 1'b0;
         end
         @(negedge clk);
         if (t == 0) req_a = 1'b1;
         if (t == 1) req_b = 1'b1;
      end
      @(negedge clk);
      chk("rr_busy_after", 32'(busy), 32'd0);

      // Request dropped and address changed during ISSUE
      @(negedge clk);
      req_a = 1'b1; we_a = 1'b0; addr_a = 8'h04;
      @(negedge clk);
      chk("drop_issue_addr", 32'(reg_addr), 32'h04);
      chk("drop_issue_busy", 32'(busy), 32'd1);
      req_a = 1'b0; addr_a = 8'h07;
      cyc = 1; got = 1'b0;
      while (!got && cyc < 10) begin
         @(negedge clk);
         cyc++;
         got = ack_a;
      end
      chk("drop_ack_seen", 32'(got), 32'd1);
      chk("drop_latency", 32'(cyc), 32'd3);
      chk("drop_rdata", 32'(rdata_a), 32'h44);
      chk("drop_err", 32'(err_a), 32'd0);
      @(negedge clk);
      chk("drop_busy_after", 32'(busy), 32'd0);

      // Reset during ISSUE of a write
      @(negedge clk);
      req_a = 1'b1; we_a = 1'b1; addr_a = 8'h01; wdata_a = 8'hAB;
      @(negedge clk);
      chk("mid_rst_we_pre", 32'(reg_we), 32'd1);
      #2;
      rst_n = 1'b0;
      req_a = 1'b0;
      #1;
      chk("mid_rst_we", 32'(reg_we), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_reg_addr", 32'(reg_addr), 32'd0);
      chk("mid_rst_reg_wdata", 32'(reg_wdata), 32'd0);
      chk("mid_rst_rdata_a", 32'(rdata_a), 32'd0);
      chk("mid_rst_rdata_b", 32'(rdata_b), 32'd0);
      repeat (2) @(negedge clk);
      chk("mid_rst_no_ack", 32'(ack_a), 32'd0);
      chk("mid_rst_mem1", 32'(mem[1]), 32'h11);
      rst_n = 1'b1;

      run_txn("b_wr00_post", 1'b1, 1'b1, 8'h00, 8'h3C, 8'h00, 1'b0);
      chk("mem0_written", 32'(mem[0]), 32'h3C);
      run_txn("b_rd00_post", 1'b1, 1'b0, 8'h00, 8'h00, 8'h3C, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
